// File: rtl/decode_issue.sv
// Single-entry decode/issue stage: holds one instruction, decodes it, and
// issues it to execute once a 4-entry busy scoreboard shows no RAW/WAW hazard.
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  ReadReg1,
  output logic [1:0]  ReadReg2,
  output logic [1:0]  WriteReg,
  output logic        RegWrite,
  output logic [2:0]  AluOp,
  output logic        UseImm,
  output logic [31:0] Imm,
  input  logic        wb_valid,
  input  logic [1:0]  wb_reg,
  input  logic        flush,
  output logic [15:0] stall_count
);

  logic        id_valid_q, id_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  busy_q, busy_d;
  logic [15:0] stall_q, stall_d;

  logic [3:0]  opcode;
  logic [1:0]  rd, rs1, rs2;
  logic        use_rs1, use_rs2;
  logic        hazard;
  logic        issue_fire;
  logic        accept;
  logic        unused_bits;

  assign opcode      = instr_q[31:28];
  assign rd          = instr_q[27:26];
  assign rs1         = instr_q[25:24];
  assign rs2         = instr_q[23:22];
  assign unused_bits = ^instr_q[21:16];

  // instr_q resets to zero (a NOP), so every decoded output reads 0 in reset
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    RegWrite = 1'b0;
    UseImm   = 1'b0;
    AluOp    = 3'd0;
    case (opcode)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        RegWrite = 1'b1;
        AluOp    = 3'(opcode - 4'h1);
      end
      4'h5: begin
        use_rs1  = 1'b1;
        RegWrite = 1'b1;
        UseImm   = 1'b1;
      end
      4'h6: begin
        RegWrite = 1'b1;
        UseImm   = 1'b1;
        AluOp    = 3'd4;
      end
      default: ;
    endcase
  end

  assign ReadReg1 = rs1;
  assign ReadReg2 = rs2;
  assign WriteReg = rd;
  assign Imm      = {{16{instr_q[15]}}, instr_q[15:0]};

  assign hazard = (use_rs1 && busy_q[rs1]) ||
                  (use_rs2 && busy_q[rs2]) ||
                  (RegWrite && busy_q[rd]);

  assign out_valid   = id_valid_q && !hazard && !flush;
  assign issue_fire  = out_valid && out_ready;
  assign in_ready    = !id_valid_q || issue_fire;
  assign accept      = in_valid && in_ready;
  assign stall_count = stall_q;

  always_comb begin
    id_valid_d = id_valid_q;
    instr_d    = instr_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_valid_d = 1'b1;
      instr_d    = in_instr;
    end else if (issue_fire) begin
      id_valid_d = 1'b0;
    end
  end

  // clear applied before set so a same-cycle set on the same register wins
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_reg] = 1'b0;
    if (issue_fire && RegWrite) busy_d[rd] = 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (id_valid_q && hazard && !flush && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid_q <= 1'b0;
      instr_q    <= 32'd0;
      busy_q     <= 4'd0;
      stall_q    <= 16'd0;
    end else begin
      id_valid_q <= id_valid_d;
      instr_q    <= instr_d;
      busy_q     <= busy_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios with literal expectations plus
// random traffic, all compared every cycle against a queue-based reference model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  ReadReg1, ReadReg2, WriteReg;
  logic        RegWrite;
  logic [2:0]  AluOp;
  logic        UseImm;
  logic [31:0] Imm;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_reg = 2'd0;
  logic        flush = 1'b0;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  decode_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .WriteReg(WriteReg), .RegWrite(RegWrite),
    .AluOp(AluOp), .UseImm(UseImm), .Imm(Imm),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       s1;
    logic       s2;
    logic       wr;
    logic       ui;
    logic [2:0] alu;
  } dec_t;

  function automatic dec_t dec(input logic [3:0] op);
    dec_t d;
    d = '0;
    if (op >= 4'h1 && op <= 4'h4) d = '{1'b1, 1'b1, 1'b1, 1'b0, 3'(op - 4'h1)};
    else if (op == 4'h5)          d = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
    else if (op == 4'h6)          d = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4};
    return d;
  endfunction

  logic [31:0] slot[$];
  bit          m_busy[4];
  int          m_sc = 0;

  function automatic bit m_hazard();
    dec_t d;
    logic [31:0] ins;
    if (slot.size() == 0) return 1'b0;
    ins = slot[0];
    d = dec(ins[31:28]);
    return (d.s1 && m_busy[ins[25:24]]) || (d.s2 && m_busy[ins[23:22]]) ||
           (d.wr && m_busy[ins[27:26]]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot.delete();
      for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
      m_sc = 0;
    end else begin
      bit held, haz, ov, fire, rdy;
      dec_t d;
      logic [31:0] ins;
      held = (slot.size() != 0);
      ins  = held ? slot[0] : 32'd0;
      d    = dec(ins[31:28]);
      haz  = m_hazard();
      ov   = held && !haz && !flush;
      fire = ov && out_ready;
      rdy  = !held || fire;
      if (wb_valid) m_busy[wb_reg] = 1'b0;
      if (fire && d.wr) m_busy[ins[27:26]] = 1'b1;
      if (held && haz && !flush && m_sc < 65535) m_sc++;
      if (fire) void'(slot.pop_front());
      if (in_valid && rdy) slot.push_back(in_instr);
      if (flush) slot.delete();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_RegWrite", 32'(RegWrite), 0);
      chk("rst_Imm", Imm, 0);
      chk("rst_stall", 32'(stall_count), 0);
      chk("rst_rr", {28'd0, ReadReg1, ReadReg2}, 0);
    end else begin
      bit held, ov;
      dec_t d;
      logic [31:0] ins;
      held = (slot.size() != 0);
      ins  = held ? slot[0] : 32'd0;
      d    = dec(ins[31:28]);
      ov   = held && !m_hazard() && !flush;
      chk("m_out_valid", 32'(out_valid), 32'(ov));
      chk("m_in_ready", 32'(in_ready), 32'(!held || (ov && out_ready)));
      chk("m_stall_count", 32'(stall_count), m_sc);
      if (held) begin
        chk("m_ReadReg1", 32'(ReadReg1), 32'(ins[25:24]));
        chk("m_ReadReg2", 32'(ReadReg2), 32'(ins[23:22]));
        chk("m_WriteReg", 32'(WriteReg), 32'(ins[27:26]));
        chk("m_RegWrite", 32'(RegWrite), 32'(d.wr));
        chk("m_AluOp", 32'(AluOp), 32'(d.alu));
        chk("m_UseImm", 32'(UseImm), 32'(d.ui));
        chk("m_Imm", Imm, {{16{ins[15]}}, ins[15:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [31:0] ins, input logic ordy,
                     input logic wbv, input logic [1:0] wbr, input logic fl);
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    wb_valid  = wbv;
    wb_reg    = wbr;
    flush     = fl;
  endtask

  task automatic do_reset();
    step();
    drv(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_stall", 32'(stall_count), 0);
    chk("reset_Imm", Imm, 0);
    step();
    reset = 1'b1;
    #1 chk("in_ready_after_reset", 32'(in_ready), 1);

    // single issue then RAW stall
    drv(1, 32'h54000005, 1, 0, 0, 0);
    step();
    drv(1, 32'h19400000, 1, 0, 0, 0);
    #1;
    chk("addi_out_valid", 32'(out_valid), 1);
    chk("addi_WriteReg", 32'(WriteReg), 1);
    chk("addi_Imm", Imm, 5);
    chk("addi_UseImm", 32'(UseImm), 1);
    chk("addi_RegWrite", 32'(RegWrite), 1);
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1;
    chk("raw_out_valid", 32'(out_valid), 0);
    chk("raw_in_ready", 32'(in_ready), 0);
    chk("raw_ReadReg1", 32'(ReadReg1), 1);
    chk("raw_stall0", 32'(stall_count), 0);
    step();
    chk("raw_stall1", 32'(stall_count), 1);
    drv(0, 0, 1, 1, 1, 0);
    #1 chk("no_bypass", 32'(out_valid), 0);
    step();
    drv(1, 32'h5C000000, 1, 0, 0, 0);
    #1;
    chk("raw_release", 32'(out_valid), 1);
    chk("raw_stall2", 32'(stall_count), 2);
    chk("add_WriteReg", 32'(WriteReg), 2);

    // same-cycle set/clear on r3
    step();
    drv(1, 32'h13C00000, 1, 1, 3, 0);
    #1;
    chk("r3_out_valid", 32'(out_valid), 1);
    chk("r3_WriteReg", 32'(WriteReg), 3);
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1 chk("set_wins", 32'(out_valid), 0);
    do_reset();

    // backpressure
    drv(1, 32'h26C00007, 0, 0, 0, 0);
    step();
    drv(1, 32'h68001234, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_AluOp", 32'(AluOp), 1);
      chk("bp_Imm", Imm, 7);
      chk("bp_rr", {28'd0, ReadReg1, ReadReg2}, 32'hB);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 1);
    step();
    drv(1, 32'h1E800000, 1, 0, 0, 0);
    #1;
    chk("lui_out_valid", 32'(out_valid), 1);
    chk("lui_AluOp", 32'(AluOp), 4);
    chk("lui_WriteReg", 32'(WriteReg), 2);
    chk("lui_Imm", Imm, 32'h1234);

    // flush while stalled
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1 chk("pre_flush_stall", 32'(out_valid), 0);
    step();
    drv(1, 32'h52000000, 1, 0, 0, 1);
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1;
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_out_valid", 32'(out_valid), 0);
    drv(1, 32'h52000000, 1, 0, 0, 0);
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1;
    chk("flush_keeps_busy", 32'(out_valid), 0);
    chk("flush_ReadReg1", 32'(ReadReg1), 2);

    // async reset mid-stall
    step();
    #1 reset = 1'b0;
    #1;
    chk("areset_out_valid", 32'(out_valid), 0);
    chk("areset_ReadReg1", 32'(ReadReg1), 0);
    chk("areset_UseImm", 32'(UseImm), 0);
    chk("areset_AluOp", 32'(AluOp), 0);
    reset = 1'b1;
    drv(1, 32'h52000000, 1, 0, 0, 0);
    step();
    drv(0, 0, 1, 0, 0, 1);
    #1 chk("flush_same_cycle", 32'(out_valid), 0);
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1 chk("flushed_empty", 32'(in_ready), 1);

    // sign extension then saturation
    drv(1, 32'h5400FFFF, 1, 0, 0, 0);
    step();
    drv(0, 0, 1, 0, 0, 0);
    #1;
    chk("sext_Imm", Imm, 32'hFFFFFFFF);
    chk("sext_out_valid", 32'(out_valid), 1);
    drv(1, 32'h11400000, 1, 0, 0, 0);
    step();
    drv(0, 0, 1, 0, 0, 0);
    repeat (65540) step();
    chk("sat_stall", 32'(stall_count), 32'hFFFF);
    chk("sat_out_valid", 32'(out_valid), 0);
    do_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = $urandom;
      in_instr[31:28] = 4'($urandom_range(0, 8));
      out_ready = ($urandom_range(0, 4) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_reg    = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 400) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    step();
    drv(0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
